// File: rtl/rv32i_types.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_types : shared RV32 types and M-extension multiply funct3s  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package rv32i_types;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  localparam int LATENCY_MUL = 3;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [4:0]  fi;
    logic [4:0]  fj;
    logic [4:0]  fk;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } fu_status_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } fu_cdb_t;

endpackage
`default_nettype wire

// File: rtl/mul_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_core : combinational 32x32 multiply with MUL/MULH* selection  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mul_core
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  output logic [31:0] result
);

  logic        a_signed;
  logic        b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    a_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU);
    b_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH);
    // Extending to 64 bits makes the modulo-2^64 product equal the exact product bits.
    a_ext    = {{32{a_signed & vj[31]}}, vj};
    b_ext    = {{32{b_signed & vk[31]}}, vk};
    prod     = a_ext * b_ext;
    result   = '0;
    case (funct3)
      FUNCT3_MUL:    result = prod[31:0];
      FUNCT3_MULH,
      FUNCT3_MULHSU,
      FUNCT3_MULHU:  result = prod[63:32];
      default:       result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fu_mul_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fu_mul_pipe : LATENCY-stage bubble-collapsing multiply unit       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fu_mul_pipe
  import rv32i_types::*;
#(
  parameter int LATENCY = LATENCY_MUL,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  fu_status_t       issue_data,
  output logic             complete_valid,
  input  logic             complete_ready,
  output fu_cdb_t          complete_data,
  output logic             exec_busy,
  output logic [CNT_W-1:0] in_flight
);

  localparam int LAST = LATENCY - 1;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [LATENCY-1:0] adv;
  fu_status_t         st_q  [LATENCY];
  fu_status_t         st_d  [LATENCY];
  logic [31:0]        res_q [LATENCY];
  logic [31:0]        res_d [LATENCY];
  logic [31:0]        mul_result;
  logic               fire_in;
  logic               full_above;
  logic [CNT_W-1:0]   cnt;

  mul_core u_mul_core (
    .funct3 (issue_data.funct3),
    .vj     (issue_data.vj),
    .vk     (issue_data.vk),
    .result (mul_result)
  );

  always_comb begin
    // A stage moves if any later stage is empty, or every later stage is full and the head retires.
    full_above = 1'b1;
    adv        = '0;
    for (int i = LAST; i >= 0; i--) begin
      adv[i]     = valid_q[i] && (!full_above || complete_ready);
      full_above = full_above && valid_q[i];
    end

    issue_ready = !flush && (!valid_q[0] || adv[0]);
    fire_in     = issue_valid && issue_ready;

    for (int i = 0; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i] && !adv[i];
      st_d[i]    = st_q[i];
      res_d[i]   = res_q[i];
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        st_d[i]    = st_q[i-1];
        res_d[i]   = res_q[i-1];
      end
    end
    if (fire_in) begin
      valid_d[0] = 1'b1;
      st_d[0]    = issue_data;
      res_d[0]   = mul_result;
    end
    if (flush) begin
      valid_d = '0;
    end

    cnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      cnt = cnt + CNT_W'(valid_q[i]);
    end
    in_flight = cnt;
    exec_busy = (cnt != '0);

    complete_valid = valid_q[LAST];
    complete_data  = '0;
    if (valid_q[LAST]) begin
      complete_data.valid     = 1'b1;
      complete_data.rd        = st_q[LAST].fi;
      complete_data.data      = res_q[LAST];
      complete_data.pc        = st_q[LAST].pc;
      complete_data.inst      = st_q[LAST].inst;
      complete_data.order     = st_q[LAST].order;
      complete_data.rs1_addr  = st_q[LAST].fj;
      complete_data.rs2_addr  = st_q[LAST].fk;
      complete_data.rs1_rdata = st_q[LAST].vj;
      complete_data.rs2_rdata = st_q[LAST].vk;
      complete_data.pc_wdata  = st_q[LAST].pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) begin
        st_q[i]  <= st_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

endmodule
`default_nettype wire
